// File: rtl/test_rdwr_thr.sv
// NLB read/write bandwidth generator: independent rd/wr streams with outstanding-CL
// throttling, multi-CL write packets, continuous restart and underflow reporting.
module test_rdwr_thr #(
  parameter int ADDR_LMT = 20,
  parameter int MDATA    = 14,
  parameter int PEND_W   = 10,
  parameter int PEND_MAX = 512,
  parameter int CLK_W    = 40
) (
  input  logic                Clk_400,
  input  logic                test_Reset,
  input  logic [1:0]          ab2rw_Mode,
  input  logic                re2xy_go,
  input  logic [31:0]         re2xy_NumLines,
  input  logic                re2xy_Cont,
  input  logic [15:0]         re2xy_stride,
  input  logic [1:0]          re2xy_multiCL_len,
  input  logic [PEND_W-1:0]   re2xy_PendLmt,
  input  logic                re2xy_wrdin_msb,
  output logic [ADDR_LMT-1:0] rw2ab_RdAddr,
  output logic [15:0]         rw2ab_RdTID,
  output logic                rw2ab_RdEn,
  output logic [1:0]          rw2ab_RdLen,
  output logic                rw2ab_RdSop,
  input  logic                ab2rw_RdSent,
  input  logic                ab2rw_RdRspValid,
  output logic [ADDR_LMT-1:0] rw2ab_WrAddr,
  output logic [15:0]         rw2ab_WrTID,
  output logic [511:0]        rw2ab_WrDin,
  output logic                rw2ab_WrEn,
  output logic [1:0]          rw2ab_WrLen,
  output logic                rw2ab_WrSop,
  input  logic                ab2rw_WrSent,
  input  logic                ab2rw_WrAlmFull,
  input  logic                ab2rw_WrRspValid,
  input  logic                ab2rw_WrRspFormat,
  input  logic [1:0]          ab2rw_WrRspCLnum,
  output logic                rw2ab_TestCmp,
  output logic                rw2ab_ErrorValid,
  output logic [255:0]        rw2ab_ErrorInfo,
  output logic [CLK_W-1:0]    rw2ab_NumClks
);
  localparam int MW = MDATA - 1;
  localparam int PW = PEND_W + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
  state_t rd_state, rd_next, wr_state, wr_next;

  logic [ADDR_LMT-1:0] rd_addr, wr_addr;
  logic [31:0]         rd_issued, wr_issued;
  logic [MW-1:0]       rd_mdata, wr_mdata;
  logic [PEND_W-1:0]   rd_pend, wr_pend;
  logic [1:0]          wr_beat;
  logic                test_cmp, running, err_valid;
  logic [255:0]        err_info, err_info_next;
  logic [CLK_W-1:0]    num_clks;

  logic [2:0]    pkt_len;
  logic [PW-1:0] lim, pkt_len_p, rd_sum, wr_sum, rd_dec, wr_dec;
  logic [32:0]   rd_issued_next, wr_issued_next;
  logic [31:0]   addr32;
  logic rd_room, wr_room, rd_en, rd_fire, rd_pass_end;
  logic wr_sop, wr_last, wr_en, wr_fire, wr_pass_end;
  logic rd_uf, wr_uf, go_acc;

  assign pkt_len   = {1'b0, re2xy_multiCL_len} + 3'd1;
  assign pkt_len_p = PW'(pkt_len);
  assign lim       = (re2xy_PendLmt != '0) ? {1'b0, re2xy_PendLmt} : PW'(PEND_MAX);
  assign rd_room   = ({1'b0, rd_pend} + pkt_len_p) <= lim;
  assign wr_room   = ({1'b0, wr_pend} + pkt_len_p) <= lim;

  assign rd_en          = (rd_state == RUN) && rd_room;
  assign rd_fire        = rd_en && ab2rw_RdSent;
  assign rd_issued_next = {1'b0, rd_issued} + 33'(pkt_len);
  assign rd_pass_end    = rd_fire && (rd_issued_next >= {1'b0, re2xy_NumLines});

  // Throttle is evaluated only at packet start so a packet is never split.
  assign wr_sop         = (wr_beat == 2'd0);
  assign wr_last        = (wr_beat == re2xy_multiCL_len);
  assign wr_en          = (wr_state == RUN) && !ab2rw_WrAlmFull && (!wr_sop || wr_room);
  assign wr_fire        = wr_en && ab2rw_WrSent;
  assign wr_issued_next = {1'b0, wr_issued} + 33'd1;
  assign wr_pass_end    = wr_fire && wr_last && (wr_issued_next >= {1'b0, re2xy_NumLines});

  // Responses are ignored in IDLE; same-cycle increment is applied before the decrement.
  assign rd_sum = {1'b0, rd_pend} + (rd_fire ? pkt_len_p : PW'(0));
  assign rd_dec = (ab2rw_RdRspValid && rd_state != IDLE) ? PW'(1) : PW'(0);
  assign rd_uf  = rd_dec > rd_sum;
  assign wr_sum = {1'b0, wr_pend} + PW'(wr_fire);
  assign wr_dec = (ab2rw_WrRspValid && wr_state != IDLE) ?
                  (ab2rw_WrRspFormat ? PW'(ab2rw_WrRspCLnum) + PW'(1) : PW'(1)) : PW'(0);
  assign wr_uf  = wr_dec > wr_sum;

  assign go_acc = re2xy_go && (rd_state == IDLE) && (wr_state == IDLE);

  always_comb begin
    rd_next = rd_state;
    wr_next = wr_state;
    case (rd_state)
      IDLE:    if (re2xy_go) rd_next = (re2xy_NumLines != '0 && ab2rw_Mode[0]) ? RUN : DONE;
      RUN:     if (rd_pass_end && !re2xy_Cont) rd_next = DONE;
      default: rd_next = rd_state;
    endcase
    case (wr_state)
      IDLE:    if (re2xy_go) wr_next = (re2xy_NumLines != '0 && ab2rw_Mode[1]) ? RUN : DONE;
      RUN:     if (wr_pass_end && !re2xy_Cont) wr_next = DONE;
      default: wr_next = wr_state;
    endcase
  end

  always_comb begin
    err_info_next        = '0;
    err_info_next[1:0]   = {wr_uf, rd_uf};
    err_info_next[47:16] = rd_uf ? rd_issued : wr_issued;
  end

  always_ff @(posedge Clk_400) begin
    if (test_Reset) begin
      rd_state  <= IDLE;
      wr_state  <= IDLE;
      rd_addr   <= '0;
      wr_addr   <= '0;
      rd_issued <= '0;
      wr_issued <= '0;
      rd_mdata  <= '0;
      wr_mdata  <= '0;
      rd_pend   <= '0;
      wr_pend   <= '0;
      wr_beat   <= '0;
      test_cmp  <= 1'b0;
      running   <= 1'b0;
      err_valid <= 1'b0;
      err_info  <= '0;
      num_clks  <= '0;
    end else begin
      rd_state <= rd_next;
      wr_state <= wr_next;

      if (rd_fire) begin
        rd_mdata <= rd_mdata + MW'(1);
        if (rd_pass_end && re2xy_Cont) begin
          rd_addr   <= '0;
          rd_issued <= '0;
        end else begin
          rd_addr   <= rd_addr + ADDR_LMT'(pkt_len) + ADDR_LMT'(re2xy_stride);
          rd_issued <= rd_issued_next[31:0];
        end
      end

      if (wr_fire) begin
        wr_mdata <= wr_mdata + MW'(1);
        if (wr_last) begin
          wr_beat <= '0;
          if (wr_pass_end && re2xy_Cont) begin
            wr_addr   <= '0;
            wr_issued <= '0;
          end else begin
            // wr_addr sits on base+L-1 here, so +1+stride lands on base+L+stride.
            wr_addr   <= wr_addr + ADDR_LMT'(1) + ADDR_LMT'(re2xy_stride);
            wr_issued <= wr_issued_next[31:0];
          end
        end else begin
          wr_beat   <= wr_beat + 2'd1;
          wr_addr   <= wr_addr + ADDR_LMT'(1);
          wr_issued <= wr_issued_next[31:0];
        end
      end

      rd_pend   <= rd_uf ? '0 : PEND_W'(rd_sum - rd_dec);
      wr_pend   <= wr_uf ? '0 : PEND_W'(wr_sum - wr_dec);
      err_valid <= rd_uf || wr_uf;
      err_info  <= (rd_uf || wr_uf) ? err_info_next : '0;

      test_cmp <= test_cmp || ((rd_state == DONE) && (wr_state == DONE) &&
                               (rd_pend == '0) && (wr_pend == '0));
      running  <= running || go_acc;
      if ((go_acc || running) && !test_cmp) num_clks <= num_clks + CLK_W'(1);
    end
  end

  assign addr32 = 32'(wr_addr);

  assign rw2ab_RdAddr     = rd_addr;
  assign rw2ab_RdEn       = rd_en;
  assign rw2ab_RdTID      = rd_en ? 16'({rd_mdata, 1'b1}) : '0;
  assign rw2ab_RdLen      = rd_en ? re2xy_multiCL_len : '0;
  assign rw2ab_RdSop      = rd_en;
  assign rw2ab_WrAddr     = wr_addr;
  assign rw2ab_WrEn       = wr_en;
  assign rw2ab_WrTID      = wr_en ? 16'({wr_mdata, 1'b0}) : '0;
  assign rw2ab_WrLen      = wr_en ? re2xy_multiCL_len : '0;
  assign rw2ab_WrSop      = wr_en && wr_sop;
  assign rw2ab_WrDin      = wr_en ? {re2xy_wrdin_msb, 31'h0, 416'h0, ~addr32, addr32} : '0;
  assign rw2ab_TestCmp    = test_cmp;
  assign rw2ab_ErrorValid = err_valid;
  assign rw2ab_ErrorInfo  = err_info;
  assign rw2ab_NumClks    = num_clks;
endmodule

// File: tb/tb_test_rdwr_thr.sv
// Directed bench for test_rdwr_thr: single-pass vector table plus throttle, packed-response,
// continuous-mode, reset and cycle-counter sequences.
module tb_test_rdwr_thr;
  logic          Clk_400 = 1'b0;
  logic          test_Reset;
  logic [1:0]    ab2rw_Mode;
  logic          re2xy_go;
  logic [31:0]   re2xy_NumLines;
  logic          re2xy_Cont;
  logic [15:0]   re2xy_stride;
  logic [1:0]    re2xy_multiCL_len;
  logic [9:0]    re2xy_PendLmt;
  logic          re2xy_wrdin_msb;
  logic [19:0]   rw2ab_RdAddr, rw2ab_WrAddr;
  logic [15:0]   rw2ab_RdTID, rw2ab_WrTID;
  logic          rw2ab_RdEn, rw2ab_RdSop, rw2ab_WrEn, rw2ab_WrSop;
  logic [1:0]    rw2ab_RdLen, rw2ab_WrLen;
  logic          ab2rw_RdSent, ab2rw_RdRspValid;
  logic [511:0]  rw2ab_WrDin;
  logic          ab2rw_WrSent, ab2rw_WrAlmFull, ab2rw_WrRspValid, ab2rw_WrRspFormat;
  logic [1:0]    ab2rw_WrRspCLnum;
  logic          rw2ab_TestCmp, rw2ab_ErrorValid;
  logic [255:0]  rw2ab_ErrorInfo;
  logic [39:0]   rw2ab_NumClks;

  always #5 Clk_400 = ~Clk_400;

  test_rdwr_thr dut (
    .Clk_400(Clk_400), .test_Reset(test_Reset), .ab2rw_Mode(ab2rw_Mode), .re2xy_go(re2xy_go),
    .re2xy_NumLines(re2xy_NumLines), .re2xy_Cont(re2xy_Cont), .re2xy_stride(re2xy_stride),
    .re2xy_multiCL_len(re2xy_multiCL_len), .re2xy_PendLmt(re2xy_PendLmt),
    .re2xy_wrdin_msb(re2xy_wrdin_msb), .rw2ab_RdAddr(rw2ab_RdAddr), .rw2ab_RdTID(rw2ab_RdTID),
    .rw2ab_RdEn(rw2ab_RdEn), .rw2ab_RdLen(rw2ab_RdLen), .rw2ab_RdSop(rw2ab_RdSop),
    .ab2rw_RdSent(ab2rw_RdSent), .ab2rw_RdRspValid(ab2rw_RdRspValid),
    .rw2ab_WrAddr(rw2ab_WrAddr), .rw2ab_WrTID(rw2ab_WrTID), .rw2ab_WrDin(rw2ab_WrDin),
    .rw2ab_WrEn(rw2ab_WrEn), .rw2ab_WrLen(rw2ab_WrLen), .rw2ab_WrSop(rw2ab_WrSop),
    .ab2rw_WrSent(ab2rw_WrSent), .ab2rw_WrAlmFull(ab2rw_WrAlmFull),
    .ab2rw_WrRspValid(ab2rw_WrRspValid), .ab2rw_WrRspFormat(ab2rw_WrRspFormat),
    .ab2rw_WrRspCLnum(ab2rw_WrRspCLnum), .rw2ab_TestCmp(rw2ab_TestCmp),
    .rw2ab_ErrorValid(rw2ab_ErrorValid), .rw2ab_ErrorInfo(rw2ab_ErrorInfo),
    .rw2ab_NumClks(rw2ab_NumClks)
  );

  typedef struct packed {
    logic [1:0]      mode;
    logic [31:0]     lines;
    logic [1:0]      len;
    logic [15:0]     stride;
    logic [7:0]      n_rd;
    logic [7:0][7:0] rd_addr;
    logic [15:0]     rd_tid;
    logic [7:0]      n_wr;
    logic [7:0][7:0] wr_addr;
    logic [7:0]      wr_sop;
    logic [15:0]     wr_tid;
  } vec_t;

  vec_t vecs [7];
  int total = 0, bad = 0, cyc = 0;
  int rd_owed, wr_owed, err_seen, beat_bad;
  bit auto_rsp;
  int rd_q[$], wr_q[$], rd_cyc_q[$];
  bit wr_sop_q[$];
  logic [15:0] rd_tid_last, wr_tid_last;

  function automatic vec_t mk(logic [1:0] mode, logic [31:0] lines, logic [1:0] len,
                              logic [15:0] stride, logic [7:0] n_rd, logic [63:0] rd_addr,
                              logic [15:0] rd_tid, logic [7:0] n_wr, logic [63:0] wr_addr,
                              logic [7:0] wr_sop, logic [15:0] wr_tid);
    vec_t v;
    v.mode = mode; v.lines = lines; v.len = len; v.stride = stride;
    v.n_rd = n_rd; v.rd_addr = rd_addr; v.rd_tid = rd_tid;
    v.n_wr = n_wr; v.wr_addr = wr_addr; v.wr_sop = wr_sop; v.wr_tid = wr_tid;
    return v;
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // One clock: edge, then sample/log at negedge and schedule responder inputs.
  task automatic tick();
    bit rf, wf;
    int L;
    @(negedge Clk_400);
    cyc++;
    L  = int'(re2xy_multiCL_len) + 1;
    rf = rw2ab_RdEn && ab2rw_RdSent;
    wf = rw2ab_WrEn && ab2rw_WrSent;
    if (rw2ab_ErrorValid) err_seen++;
    if (rf) begin
      rd_q.push_back(int'(rw2ab_RdAddr));
      rd_cyc_q.push_back(cyc);
      rd_tid_last = rw2ab_RdTID;
      if (rw2ab_RdLen != re2xy_multiCL_len || !rw2ab_RdSop) beat_bad++;
    end
    if (wf) begin
      wr_q.push_back(int'(rw2ab_WrAddr));
      wr_sop_q.push_back(rw2ab_WrSop);
      wr_tid_last = rw2ab_WrTID;
      if (rw2ab_WrLen != re2xy_multiCL_len) beat_bad++;
      if (rw2ab_WrDin[31:0] != 32'(rw2ab_WrAddr) || rw2ab_WrDin[63:32] != ~32'(rw2ab_WrAddr) ||
          rw2ab_WrDin[510:64] != '0 || rw2ab_WrDin[511] != re2xy_wrdin_msb) beat_bad++;
    end
    if (auto_rsp) begin
      ab2rw_RdRspValid = rd_owed > 0;
      if (rd_owed > 0) rd_owed--;
      ab2rw_WrRspValid = wr_owed > 0;
      if (wr_owed > 0) wr_owed--;
      if (rf) rd_owed += L;
      if (wf) wr_owed += 1;
    end
  endtask

  task automatic do_reset();
    test_Reset = 1'b1; re2xy_go = 1'b0; re2xy_Cont = 1'b0; re2xy_PendLmt = '0;
    ab2rw_RdRspValid = 1'b0; ab2rw_WrRspValid = 1'b0; ab2rw_WrRspFormat = 1'b0;
    ab2rw_WrRspCLnum = '0; ab2rw_WrAlmFull = 1'b0; ab2rw_RdSent = 1'b1; ab2rw_WrSent = 1'b1;
    auto_rsp = 1'b0; rd_owed = 0; wr_owed = 0;
    tick(); tick();
    test_Reset = 1'b0;
    rd_q.delete(); wr_q.delete(); rd_cyc_q.delete(); wr_sop_q.delete();
    err_seen = 0; beat_bad = 0; rd_tid_last = '0; wr_tid_last = '0;
  endtask

  task automatic start(logic [1:0] mode, logic [31:0] lines, logic [1:0] len, logic [15:0] stride);
    ab2rw_Mode = mode; re2xy_NumLines = lines; re2xy_multiCL_len = len; re2xy_stride = stride;
    re2xy_go = 1'b1;
    tick();
    re2xy_go = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int exp_c[8];
    test_Reset = 1'b1; ab2rw_Mode = '0; re2xy_go = 1'b0; re2xy_NumLines = '0; re2xy_Cont = 1'b0;
    re2xy_stride = '0; re2xy_multiCL_len = '0; re2xy_PendLmt = '0; re2xy_wrdin_msb = 1'b0;
    ab2rw_RdSent = 1'b1; ab2rw_RdRspValid = 1'b0; ab2rw_WrSent = 1'b1; ab2rw_WrAlmFull = 1'b0;
    ab2rw_WrRspValid = 1'b0; ab2rw_WrRspFormat = 1'b0; ab2rw_WrRspCLnum = '0;

    vecs[0] = mk(2'b01, 8, 0, 0, 8, {8'd7,8'd6,8'd5,8'd4,8'd3,8'd2,8'd1,8'd0}, 16'd15,
                 0, 64'd0, 8'd0, 16'd0);
    vecs[1] = mk(2'b10, 8, 3, 2, 0, 64'd0, 16'd0,
                 8, {8'd9,8'd8,8'd7,8'd6,8'd3,8'd2,8'd1,8'd0}, 8'b0001_0001, 16'd14);
    vecs[2] = mk(2'b11, 4, 1, 1, 2, {48'd0,8'd3,8'd0}, 16'd3,
                 4, {32'd0,8'd4,8'd3,8'd1,8'd0}, 8'b0000_0101, 16'd6);
    vecs[3] = mk(2'b01, 5, 1, 0, 3, {40'd0,8'd4,8'd2,8'd0}, 16'd5, 0, 64'd0, 8'd0, 16'd0);
    vecs[4] = mk(2'b00, 8, 0, 0, 0, 64'd0, 16'd0, 0, 64'd0, 8'd0, 16'd0);
    vecs[5] = mk(2'b11, 0, 2, 0, 0, 64'd0, 16'd0, 0, 64'd0, 8'd0, 16'd0);
    vecs[6] = mk(2'b10, 3, 1, 0, 0, 64'd0, 16'd0,
                 4, {32'd0,8'd3,8'd2,8'd1,8'd0}, 8'b0000_0101, 16'd6);

    // Single-pass vectors with an auto responder, no throttling.
    for (int i = 0; i < 7; i++) begin
      do_reset();
      re2xy_wrdin_msb = i[0];
      auto_rsp = 1'b1;
      start(vecs[i].mode, vecs[i].lines, vecs[i].len, vecs[i].stride);
      n = 0;
      while (!rw2ab_TestCmp && n < 300) begin tick(); n++; end
      chk($sformatf("v%0d_testcmp", i), rw2ab_TestCmp, 1);
      chk($sformatf("v%0d_nrd", i), rd_q.size(), vecs[i].n_rd);
      chk($sformatf("v%0d_nwr", i), wr_q.size(), vecs[i].n_wr);
      for (int k = 0; k < int'(vecs[i].n_rd) && k < rd_q.size(); k++)
        chk($sformatf("v%0d_rdaddr%0d", i, k), rd_q[k], vecs[i].rd_addr[k]);
      for (int k = 0; k < int'(vecs[i].n_wr) && k < wr_q.size(); k++) begin
        chk($sformatf("v%0d_wraddr%0d", i, k), wr_q[k], vecs[i].wr_addr[k]);
        chk($sformatf("v%0d_wrsop%0d", i, k), wr_sop_q[k], vecs[i].wr_sop[k]);
      end
      if (vecs[i].n_rd != 0) chk($sformatf("v%0d_rdtid", i), rd_tid_last, vecs[i].rd_tid);
      if (vecs[i].n_wr != 0) chk($sformatf("v%0d_wrtid", i), wr_tid_last, vecs[i].wr_tid);
      chk($sformatf("v%0d_beat_fields", i), beat_bad, 0);
      chk($sformatf("v%0d_no_err", i), err_seen, 0);
    end

    // Throttle: limit 4, 2-CL packets, responses withheld.
    do_reset();
    re2xy_PendLmt = 10'd4;
    start(2'b01, 100, 1, 0);
    repeat (8) tick();
    chk("thr_sent", rd_q.size(), 2);
    chk("thr_addr1", rd_q.size() > 1 ? rd_q[1] : -1, 2);
    chk("thr_en_low", rw2ab_RdEn, 0);
    ab2rw_RdRspValid = 1'b1; tick(); ab2rw_RdRspValid = 1'b0;
    chk("thr_pend3_low", rw2ab_RdEn, 0);
    tick();
    chk("thr_pend3_low2", rw2ab_RdEn, 0);
    ab2rw_RdRspValid = 1'b1; tick(); ab2rw_RdRspValid = 1'b0;
    chk("thr_pend2_high", rw2ab_RdEn, 1);

    // Packed write response, then spurious responses.
    do_reset();
    start(2'b10, 4, 3, 0);
    repeat (8) tick();
    chk("pk_beats", wr_q.size(), 4);
    chk("pk_cmp_pending", rw2ab_TestCmp, 0);
    ab2rw_WrRspValid = 1'b1; ab2rw_WrRspFormat = 1'b1; ab2rw_WrRspCLnum = 2'd3;
    tick();
    ab2rw_WrRspValid = 1'b0; ab2rw_WrRspFormat = 1'b0; ab2rw_WrRspCLnum = 2'd0;
    tick();
    chk("pk_cmp", rw2ab_TestCmp, 1);
    chk("pk_no_err", err_seen, 0);
    ab2rw_WrRspValid = 1'b1; tick(); ab2rw_WrRspValid = 1'b0;
    chk("uf_wr_valid", rw2ab_ErrorValid, 1);
    chk("uf_wr_code", rw2ab_ErrorInfo[7:0], 2);
    chk("uf_wr_issued", rw2ab_ErrorInfo[47:16], 4);
    chk("uf_wr_rest", (rw2ab_ErrorInfo[255:48] != '0) || (rw2ab_ErrorInfo[15:8] != '0), 0);
    tick();
    chk("uf_pulse_end", rw2ab_ErrorValid, 0);
    ab2rw_WrRspValid = 1'b1; ab2rw_RdRspValid = 1'b1; tick();
    ab2rw_WrRspValid = 1'b0; ab2rw_RdRspValid = 1'b0;
    chk("uf_both_code", rw2ab_ErrorInfo[7:0], 3);
    chk("uf_cmp_sticky", rw2ab_TestCmp, 1);

    // Continuous mode: restart with no bubble, Cont dropped during the second pass.
    do_reset();
    re2xy_Cont = 1'b1; auto_rsp = 1'b1;
    start(2'b01, 4, 0, 0);
    n = 0;
    while (rd_q.size() < 6 && n < 50) begin tick(); n++; end
    re2xy_Cont = 1'b0;
    n = 0;
    while (!rw2ab_TestCmp && n < 100) begin tick(); n++; end
    chk("cont_cmp", rw2ab_TestCmp, 1);
    chk("cont_sent", rd_q.size(), 8);
    exp_c = '{0, 1, 2, 3, 0, 1, 2, 3};
    for (int k = 0; k < 8 && k < rd_q.size(); k++)
      chk($sformatf("cont_addr%0d", k), rd_q[k], exp_c[k]);
    if (rd_cyc_q.size() >= 8) chk("cont_no_bubble", rd_cyc_q[7] - rd_cyc_q[0], 7);
    else chk("cont_no_bubble", rd_cyc_q.size(), 8);

    // Reset mid-run, then late responses while IDLE.
    do_reset();
    start(2'b11, 100, 0, 0);
    repeat (3) tick();
    chk("rst_pre_rden", rw2ab_RdEn, 1);
    ab2rw_WrAlmFull = 1'b1; #1;
    chk("almfull_wren", rw2ab_WrEn, 0);
    ab2rw_WrAlmFull = 1'b0;
    test_Reset = 1'b1; tick(); test_Reset = 1'b0;
    chk("rst_en", {rw2ab_RdEn, rw2ab_WrEn, rw2ab_RdSop, rw2ab_WrSop}, 0);
    chk("rst_addr", {rw2ab_RdAddr, rw2ab_WrAddr}, 0);
    chk("rst_tid", {rw2ab_RdTID, rw2ab_WrTID}, 0);
    chk("rst_din", rw2ab_WrDin != '0, 0);
    chk("rst_len", {rw2ab_RdLen, rw2ab_WrLen}, 0);
    chk("rst_status", {rw2ab_TestCmp, rw2ab_ErrorValid, rw2ab_ErrorInfo != '0}, 0);
    chk("rst_numclks", rw2ab_NumClks, 0);
    ab2rw_RdRspValid = 1'b1; ab2rw_WrRspValid = 1'b1; tick();
    ab2rw_RdRspValid = 1'b0; ab2rw_WrRspValid = 1'b0;
    chk("late_rsp_no_err", rw2ab_ErrorValid, 0);
    tick();
    chk("late_rsp_idle", {rw2ab_RdEn, rw2ab_WrEn, rw2ab_ErrorValid}, 0);

    // Cycle counter: nothing enabled, both sides finish on go.
    do_reset();
    start(2'b00, 8, 0, 0);
    repeat (4) tick();
    chk("nclk_cmp", rw2ab_TestCmp, 1);
    chk("nclk_val", rw2ab_NumClks, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
